// File: rtl/ccip_txn_tracker.sv
// rtl/ccip_txn_tracker.sv - per-channel CCI-P request/response tracker
//
// Purpose: matches requests to responses by mdata tag on NUM_CH independent
// channels. Reports outstanding/completed counts and maximum latency, and
// flags duplicate tags, orphan responses, over-completion and timeouts.
//
// Optional feature: define CCIP_TRACKER_LOG_EN to report one line per error
// event (simulation only). Outputs are identical in both builds.
//
// Ports:
//   clk, SoftReset (async, active-high)
//   clear_stats             - zero completed/max_latency/err_* next cycle
//   req_valid/tag/len       - request per channel (len = CLs - 1)
//   rsp_valid/tag/ncl       - response per channel (ncl = CLs - 1)
//   outstanding             - valid entries per channel
//   completed               - saturating count of normal completions
//   max_latency             - largest completion latency seen
//   err_dup_tag/err_orphan/err_overcomplete/err_timeout - sticky flags
module ccip_txn_tracker #(
  parameter int NUM_CH    = 2,
  parameter int TAG_WIDTH = 16,
  parameter int IDX_WIDTH = 6,
  parameter int TS_WIDTH  = 32,
  parameter int TIMEOUT   = 4096,
  parameter     LOGNAME   = "ccip_tracker.log"
) (
  input  logic                              clk,
  input  logic                              SoftReset,
  input  logic                              clear_stats,
  input  logic [NUM_CH-1:0]                 req_valid,
  input  logic [NUM_CH*TAG_WIDTH-1:0]       req_tag,
  input  logic [NUM_CH*2-1:0]               req_len,
  input  logic [NUM_CH-1:0]                 rsp_valid,
  input  logic [NUM_CH*TAG_WIDTH-1:0]       rsp_tag,
  input  logic [NUM_CH*2-1:0]               rsp_ncl,
  output logic [NUM_CH*(IDX_WIDTH+1)-1:0]   outstanding,
  output logic [NUM_CH*32-1:0]              completed,
  output logic [NUM_CH*TS_WIDTH-1:0]        max_latency,
  output logic [NUM_CH-1:0]                 err_dup_tag,
  output logic [NUM_CH-1:0]                 err_orphan,
  output logic [NUM_CH-1:0]                 err_overcomplete,
  output logic [NUM_CH-1:0]                 err_timeout
);

  localparam int DEPTH = 2 ** IDX_WIDTH;
  localparam int UPW   = TAG_WIDTH - IDX_WIDTH;
  localparam int CW    = IDX_WIDTH + 1;
  localparam logic [TS_WIDTH-1:0] TIMEOUT_TS = TS_WIDTH'(TIMEOUT);

  // Free-running timestamp shared by all channels.
  logic [TS_WIDTH-1:0] now;

  always_ff @(posedge clk or posedge SoftReset) begin
    if (SoftReset) now <= '0;
    else           now <= now + 1'b1;
  end

  logic unused_logname;
  assign unused_logname = ^LOGNAME;

  for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
    logic [TAG_WIDTH-1:0] rq_tag, rs_tag;
    logic [IDX_WIDTH-1:0] rq_idx, rs_idx;
    logic [UPW-1:0]       rq_up, rs_up;
    logic [1:0]           rq_len, rs_ncl;

    assign rq_tag = req_tag[ch*TAG_WIDTH +: TAG_WIDTH];
    assign rs_tag = rsp_tag[ch*TAG_WIDTH +: TAG_WIDTH];
    assign rq_idx = rq_tag[IDX_WIDTH-1:0];
    assign rs_idx = rs_tag[IDX_WIDTH-1:0];
    assign rq_up  = rq_tag[TAG_WIDTH-1:IDX_WIDTH];
    assign rs_up  = rs_tag[TAG_WIDTH-1:IDX_WIDTH];
    assign rq_len = req_len[ch*2 +: 2];
    assign rs_ncl = rsp_ncl[ch*2 +: 2];

    // Table: control bits carry reset, payload arrays do not need it.
    logic [DEPTH-1:0]    e_valid;
    logic [DEPTH-1:0]    e_timed_out;
    logic [UPW-1:0]      e_up [DEPTH];
    logic [2:0]          e_rem [DEPTH];
    logic [TS_WIDTH-1:0] e_ts [DEPTH];

    logic [IDX_WIDTH-1:0] scan_ptr;
    logic [CW-1:0]        cnt_q;
    logic [31:0]          cmp_q;
    logic [TS_WIDTH-1:0]  max_q;
    logic                 dup_q, orp_q, ovr_q, to_q;

    logic                rs_hit, rs_orphan, rs_partial, rs_done, rs_over, rs_free;
    logic [2:0]          rs_n;
    logic [TS_WIDTH-1:0] rs_lat;
    logic                rq_dup, rq_new, sc_hit;

    // Response is judged against the old table state; a request then sees
    // the entry as free if that response released it in the same cycle.
    always_comb begin
      rs_n       = {1'b0, rs_ncl} + 3'd1;
      rs_hit     = rsp_valid[ch] && e_valid[rs_idx] && (e_up[rs_idx] == rs_up);
      rs_orphan  = rsp_valid[ch] && !rs_hit;
      rs_partial = rs_hit && (rs_n <  e_rem[rs_idx]);
      rs_done    = rs_hit && (rs_n == e_rem[rs_idx]);
      rs_over    = rs_hit && (rs_n >  e_rem[rs_idx]);
      rs_free    = rs_done || rs_over;
      rs_lat     = now - e_ts[rs_idx];
      rq_dup     = req_valid[ch] && e_valid[rq_idx] && !(rs_free && (rs_idx == rq_idx));
      rq_new     = req_valid[ch] && !rq_dup;
      sc_hit     = e_valid[scan_ptr] && !e_timed_out[scan_ptr] &&
                   ((now - e_ts[scan_ptr]) >= TIMEOUT_TS);
    end

    always_ff @(posedge clk) begin
      if (rs_partial) e_rem[rs_idx] <= e_rem[rs_idx] - rs_n;
      if (req_valid[ch]) begin
        e_up[rq_idx]  <= rq_up;
        e_rem[rq_idx] <= {1'b0, rq_len} + 3'd1;
        e_ts[rq_idx]  <= now;
      end
    end

    always_ff @(posedge clk or posedge SoftReset) begin
      if (SoftReset) begin
        e_valid     <= '0;
        e_timed_out <= '0;
        scan_ptr    <= '0;
        cnt_q       <= '0;
        cmp_q       <= '0;
        max_q       <= '0;
        dup_q       <= 1'b0;
        orp_q       <= 1'b0;
        ovr_q       <= 1'b0;
        to_q        <= 1'b0;
      end else begin
        // Later assignments win: scan, then response, then request.
        if (sc_hit)        e_timed_out[scan_ptr] <= 1'b1;
        if (rs_free)       e_valid[rs_idx]       <= 1'b0;
        if (req_valid[ch]) begin
          e_valid[rq_idx]     <= 1'b1;
          e_timed_out[rq_idx] <= 1'b0;
        end
        scan_ptr <= scan_ptr + 1'b1;
        cnt_q    <= cnt_q + CW'(rq_new) - CW'(rs_free);

        if (clear_stats) begin
          cmp_q <= '0;
          max_q <= '0;
        end else if (rs_done) begin
          if (cmp_q != '1)     cmp_q <= cmp_q + 32'd1;
          if (rs_lat > max_q)  max_q <= rs_lat;
        end

        // A new error in the clearing cycle still sets the flag.
        dup_q <= rq_dup    || (dup_q && !clear_stats);
        orp_q <= rs_orphan || (orp_q && !clear_stats);
        ovr_q <= rs_over   || (ovr_q && !clear_stats);
        to_q  <= sc_hit    || (to_q  && !clear_stats);
      end
    end

    assign outstanding[ch*CW +: CW]             = cnt_q;
    assign completed[ch*32 +: 32]               = cmp_q;
    assign max_latency[ch*TS_WIDTH +: TS_WIDTH] = max_q;
    assign err_dup_tag[ch]                      = dup_q;
    assign err_orphan[ch]                       = orp_q;
    assign err_overcomplete[ch]                 = ovr_q;
    assign err_timeout[ch]                      = to_q;

`ifdef CCIP_TRACKER_LOG_EN
    always @(posedge clk) begin
      if (!SoftReset) begin
        if (rq_dup)    $display("%0t %0d %h DUP", $time, ch, rq_tag);
        if (rs_orphan) $display("%0t %0d %h ORPHAN", $time, ch, rs_tag);
        if (rs_over)   $display("%0t %0d %h OVERCOMPLETE", $time, ch, rs_tag);
        if (sc_hit)    $display("%0t %0d %h TIMEOUT", $time, ch,
                                {e_up[scan_ptr], scan_ptr});
      end
    end
`endif
  end

endmodule

// File: tb/tb_ccip_txn_tracker.sv
// tb/tb_ccip_txn_tracker.sv - directed self-checking bench for ccip_txn_tracker
module tb_ccip_txn_tracker;

  logic        clk = 1'b0;
  logic        SoftReset = 1'b1;
  logic        clear_stats = 1'b0;
  logic [1:0]  req_valid = '0;
  logic [31:0] req_tag = '0;
  logic [3:0]  req_len = '0;
  logic [1:0]  rsp_valid = '0;
  logic [31:0] rsp_tag = '0;
  logic [3:0]  rsp_ncl = '0;
  logic [9:0]  outstanding;
  logic [63:0] completed;
  logic [63:0] max_latency;
  logic [1:0]  err_dup_tag, err_orphan, err_overcomplete, err_timeout;

  int n_tests = 0;
  int n_fail  = 0;
  int k;

  ccip_txn_tracker #(.IDX_WIDTH(4), .TIMEOUT(64)) dut (
    .clk(clk), .SoftReset(SoftReset), .clear_stats(clear_stats),
    .req_valid(req_valid), .req_tag(req_tag), .req_len(req_len),
    .rsp_valid(rsp_valid), .rsp_tag(rsp_tag), .rsp_ncl(rsp_ncl),
    .outstanding(outstanding), .completed(completed), .max_latency(max_latency),
    .err_dup_tag(err_dup_tag), .err_orphan(err_orphan),
    .err_overcomplete(err_overcomplete), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    req_valid   = '0;
    rsp_valid   = '0;
    clear_stats = 1'b0;
  endtask

  task automatic set_req(input int ch, input logic [15:0] tag, input logic [1:0] len);
    req_valid[ch]         = 1'b1;
    req_tag[ch*16 +: 16]  = tag;
    req_len[ch*2 +: 2]    = len;
  endtask

  task automatic set_rsp(input int ch, input logic [15:0] tag, input logic [1:0] ncl);
    rsp_valid[ch]         = 1'b1;
    rsp_tag[ch*16 +: 16]  = tag;
    rsp_ncl[ch*2 +: 2]    = ncl;
  endtask

  task automatic do_clear();
    clear_stats = 1'b1;
    tick();
    idle();
  endtask

  function automatic logic [7:0] errs(input int ch);
    return {4'd0, err_dup_tag[ch], err_orphan[ch], err_overcomplete[ch], err_timeout[ch]};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // Reset state
    tick();
    check("rst_outstanding", outstanding, 0);
    check("rst_completed", completed, 0);
    check("rst_max_latency", max_latency, 0);
    check("rst_errors", {err_dup_tag, err_orphan, err_overcomplete, err_timeout}, 0);
    SoftReset = 1'b0;
    tick();

    // T1: 4CL read completed by four 1CL responses, last one 7 cycles later
    set_req(0, 16'h0005, 2'd3);
    tick();
    idle();
    check("t1_out_after_req", outstanding[4:0], 1);
    tick(); tick(); tick();
    set_rsp(0, 16'h0005, 2'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      if (i == 2) check("t1_out_partial", outstanding[4:0], 1);
    end
    idle();
    check("t1_out_done", outstanding[4:0], 0);
    check("t1_completed", completed[31:0], 1);
    check("t1_max_latency", max_latency[31:0], 7);
    check("t1_errors", errs(0), 0);

    // T2: ch1 2CL write, one 2CL response 20 cycles later, then orphan with clear
    set_req(1, 16'h0042, 2'd1);
    tick();
    idle();
    repeat (19) tick();
    set_rsp(1, 16'h0042, 2'd1);
    tick();
    idle();
    check("t2_completed", completed[63:32], 1);
    check("t2_max_latency", max_latency[63:32], 20);
    check("t2_out", outstanding[9:5], 0);
    check("t2_ch0_untouched", completed[31:0], 1);
    set_rsp(1, 16'h0042, 2'd0);
    clear_stats = 1'b1;
    tick();
    idle();
    check("t2_orphan_beats_clear", err_orphan[1], 1);
    check("t2_clear_completed", completed, 0);
    check("t2_out_after_orphan", outstanding[9:5], 0);
    do_clear();
    check("t2_clear_errors", {err_dup_tag, err_orphan, err_overcomplete, err_timeout}, 0);

    // T3: same index, different upper bits -> dup; stale tag -> orphan
    set_req(0, 16'h0003, 2'd0);
    tick();
    idle();
    set_req(0, 16'h0043, 2'd0);
    tick();
    idle();
    check("t3_dup", err_dup_tag[0], 1);
    check("t3_out_dup", outstanding[4:0], 1);
    set_rsp(0, 16'h0003, 2'd0);
    tick();
    idle();
    check("t3_orphan", err_orphan[0], 1);
    check("t3_out_orphan", outstanding[4:0], 1);
    set_rsp(0, 16'h0043, 2'd0);
    tick();
    idle();
    check("t3_out_freed", outstanding[4:0], 0);
    check("t3_completed", completed[31:0], 1);
    do_clear();

    // T4: same-cycle free and reallocate, then over-completion
    set_req(0, 16'h0007, 2'd0);
    tick();
    idle();
    tick(); tick();
    set_rsp(0, 16'h0007, 2'd0);
    set_req(0, 16'h0007, 2'd0);
    tick();
    idle();
    check("t4_no_dup", err_dup_tag[0], 0);
    check("t4_out_realloc", outstanding[4:0], 1);
    check("t4_completed", completed[31:0], 1);
    set_rsp(0, 16'h0007, 2'd2);
    tick();
    idle();
    check("t4_overcomplete", err_overcomplete[0], 1);
    check("t4_out_over", outstanding[4:0], 0);
    check("t4_completed_held", completed[31:0], 1);
    do_clear();

    // T5: timeout on ch1, late response still completes
    set_req(1, 16'h0009, 2'd0);
    tick();
    idle();
    k = 0;
    for (int i = 1; i <= 90; i++) begin
      tick();
      if (err_timeout[1]) begin
        k = i;
        break;
      end
    end
    check("t5_timeout_seen", k != 0, 1);
    check("t5_timeout_not_early", k >= 64, 1);
    check("t5_timeout_bound", k <= 80, 1);
    check("t5_ch0_no_timeout", err_timeout[0], 0);
    check("t5_out_still_valid", outstanding[9:5], 1);
    set_rsp(1, 16'h0009, 2'd0);
    tick();
    idle();
    check("t5_late_completed", completed[63:32], 1);
    check("t5_latency_gt_timeout", max_latency[63:32] > 64, 1);
    check("t5_latency_exact", max_latency[63:32], k + 1);
    do_clear();
    check("t5_clear_completed", completed[63:32], 0);
    check("t5_clear_max", max_latency[63:32], 0);
    check("t5_clear_timeout", err_timeout[1], 0);

    // T6: asynchronous reset with 5 outstanding per channel
    for (int i = 0; i < 5; i++) begin
      set_req(0, 16'h0010 + 16'(i), 2'd0);
      set_req(1, 16'h0010 + 16'(i), 2'd0);
      tick();
    end
    idle();
    check("t6_out_before_reset", outstanding, {5'd5, 5'd5});
    @(posedge clk);
    #3 SoftReset = 1'b1;
    #1;
    check("t6_async_out", outstanding, 0);
    check("t6_async_stats", {completed, max_latency}, 0);
    check("t6_async_errors", {err_dup_tag, err_orphan, err_overcomplete, err_timeout}, 0);
    #2 SoftReset = 1'b0;
    tick();
    set_rsp(0, 16'h0010, 2'd0);
    tick();
    idle();
    check("t6_post_reset_orphan", err_orphan[0], 1);
    check("t6_post_reset_out", outstanding[4:0], 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
